filter_accel_mul_arb: RTL and testbench

FILTER_ACCEL_MUL_ARB -- requirements
Module: filter_accel_mul_arb

---
 rtl/filter_accel_mul_arb.sv | 138 +++++++++++++
 tb/tb_filter_accel_mul_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_accel_mul_arb.sv
// Four-way round-robin arbiter feeding one shared signed x unsigned multiplier.
// Define FILTER_ACCEL_MUL_ARB_SAT_EN to clamp products to signed 16-bit.
module filter_accel_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 11,
  parameter int P_WIDTH = 19
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [P_WIDTH-1:0]         res_p,
  output logic [1:0]                 res_id
);

  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [A_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [B_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [1:0]         s1_id_q, s1_id_d;
  logic               s2_valid_q, s2_valid_d;
  logic [P_WIDTH-1:0] s2_p_q, s2_p_d;
  logic [1:0]         s2_id_q, s2_id_d;

  logic               gnt_found;
  logic [1:0]         gnt_id;
  logic [1:0]         cand;
  logic               advance;
  logic               hs;
  logic [A_WIDTH-1:0] a_sel;
  logic [B_WIDTH-1:0] b_sel;

  logic signed [P_WIDTH-1:0] a_ext;
  logic signed [P_WIDTH-1:0] b_ext;
  logic signed [P_WIDTH-1:0] prod;
  logic [P_WIDTH-1:0]        prod_st;

  // round-robin search starting at rr_ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign advance = !s2_valid_q || res_ready;
  assign hs      = ap_rst_n && gnt_found && advance;
  assign a_sel   = req_a[int'(gnt_id)*A_WIDTH +: A_WIDTH];
  assign b_sel   = req_b[int'(gnt_id)*B_WIDTH +: B_WIDTH];

  // one-hot ready for the granted requester when the pipe can move
  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_id] = 1'b1;
  end

  // B is zero-extended so it is never read as negative
  assign a_ext = {{(P_WIDTH-A_WIDTH){s1_a_q[A_WIDTH-1]}}, s1_a_q};
  assign b_ext = {{(P_WIDTH-B_WIDTH){1'b0}}, s1_b_q};
  assign prod  = a_ext * b_ext;

`ifdef FILTER_ACCEL_MUL_ARB_SAT_EN
  localparam logic signed [P_WIDTH-1:0] SAT_MAX = P_WIDTH'(32767);
  localparam logic signed [P_WIDTH-1:0] SAT_MIN = -P_WIDTH'(32768);

  // clamp to the signed 16-bit range before it is registered
  always_comb begin
    prod_st = prod;
    if (prod > SAT_MAX)      prod_st = SAT_MAX;
    else if (prod < SAT_MIN) prod_st = SAT_MIN;
  end
`else
  assign prod_st = prod;
`endif

  // next-state for both pipeline stages and the arbiter pointer
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_id_d    = s2_id_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_p_d     = prod_st;
      s2_id_d    = s1_id_q;
      s1_valid_d = hs;
      if (hs) begin
        s1_a_d   = a_sel;
        s1_b_d   = b_sel;
        s1_id_d  = gnt_id;
        rr_ptr_d = gnt_id + 2'd1;
      end
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_id_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign res_valid = s2_valid_q;
  assign res_p     = s2_p_q;
  assign res_id    = s2_id_q;

endmodule

// File: tb/tb_filter_accel_mul_arb.sv
// Directed bench for filter_accel_mul_arb.
// Checks reset, latency, round robin, stall, extremes and withdraw.
module tb_filter_accel_mul_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [43:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [18:0] res_p;
  logic [1:0]  res_id;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FILTER_ACCEL_MUL_ARB_SAT_EN
  localparam int EXP_MIN = -32768;
  localparam int EXP_MAX = 32767;
`else
  localparam int EXP_MIN = -262016;
  localparam int EXP_MAX = 259969;
`endif

  always #5 clk = ~clk;

  filter_accel_mul_arb dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    logic [7:0]  av;
    logic [10:0] bv;
    av = a[7:0];
    bv = b[10:0];
    req_a[i*8 +: 8]   = av;
    req_b[i*11 +: 11] = bv;
  endtask

  function automatic logic [31:0] p19(input int v);
    return {13'b0, v[18:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int id, input int p);
    chk({tag, "_v"}, {31'b0, res_valid}, 32'd1);
    chk({tag, "_id"}, {30'b0, res_id}, id);
    chk({tag, "_p"}, {13'b0, res_p}, p19(p));
  endtask

  int prod_tab [4];

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    settle();
    chk("rst_ready_low", {28'b0, req_ready}, 32'd0);
    tick();
    tick();
    chk("rst_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_p", {13'b0, res_p}, 32'd0);
    chk("rst_id", {30'b0, res_id}, 32'd0);
    chk("rst_ready", {28'b0, req_ready}, 32'd0);

    // single op, 2-cycle latency
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    set_op(0, -3, 5);
    settle();
    chk("t1_ready", {28'b0, req_ready}, 32'b0001);
    tick();
    req_valid = 4'b0000;
    settle();
    chk("t1_lat1", {31'b0, res_valid}, 32'd0);
    tick();
    chk_res("t1_res", 0, -15);
    tick();
    chk("t1_drain", {31'b0, res_valid}, 32'd0);

    // reset so round robin starts at 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(i, i + 1, 10 * (i + 1));
      prod_tab[i] = (i + 1) * 10 * (i + 1);
    end
    req_valid = 4'b1111;
    settle();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_ready%0d", k), {28'b0, req_ready},
          32'(1 << (k % 4)));
      if (k >= 2)
        chk_res($sformatf("rr_res%0d", k), (k - 2) % 4,
                prod_tab[(k - 2) % 4]);
      tick();
    end

    // stall with ids 2 and 3 in flight
    res_ready = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("st_ready%0d", k), {28'b0, req_ready}, 32'd0);
      chk_res($sformatf("st_hold%0d", k), 2, prod_tab[2]);
      tick();
    end
    req_valid = 4'b0000;
    res_ready = 1'b1;
    settle();
    chk_res("st_out0", 2, prod_tab[2]);
    tick();
    chk_res("st_out1", 3, prod_tab[3]);
    tick();
    chk("st_empty", {31'b0, res_valid}, 32'd0);

    // extremes back to back
    req_valid = 4'b0001;
    set_op(0, -128, 2047);
    settle();
    chk("ex_ready0", {28'b0, req_ready}, 32'b0001);
    tick();
    req_valid = 4'b0010;
    set_op(1, 127, 2047);
    settle();
    chk("ex_ready1", {28'b0, req_ready}, 32'b0010);
    tick();
    req_valid = 4'b0000;
    settle();
    chk_res("ex_min", 0, EXP_MIN);
    tick();
    chk_res("ex_max", 1, EXP_MAX);
    tick();

    // reset with both stages full
    req_valid = 4'b1111;
    settle();
    chk("mr_ready_a", {28'b0, req_ready}, 32'b0100);
    tick();
    tick();
    rst_n = 1'b0;
    settle();
    chk("mr_ready_rst", {28'b0, req_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("mr_valid", {31'b0, res_valid}, 32'd0);
    chk("mr_tie0", {28'b0, req_ready}, 32'b0001);
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mr_stale%0d", k), {31'b0, res_valid}, 32'd0);
    end

    // requester 2 withdraws while 1 is granted but stalled
    res_ready = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 2, 3);
    settle();
    chk("wd_ready0", {28'b0, req_ready}, 32'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b0110;
    set_op(1, -7, 100);
    set_op(2, 5, 9);
    settle();
    chk("wd_stall_a", {28'b0, req_ready}, 32'd0);
    chk_res("wd_r0a", 0, 6);
    tick();
    req_valid = 4'b0010;
    settle();
    chk("wd_stall_b", {28'b0, req_ready}, 32'd0);
    chk_res("wd_r0b", 0, 6);
    tick();
    res_ready = 1'b1;
    settle();
    chk("wd_ready1", {28'b0, req_ready}, 32'b0010);
    chk_res("wd_r0c", 0, 6);
    tick();
    req_valid = 4'b0000;
    settle();
    chk("wd_bubble", {31'b0, res_valid}, 32'd0);
    tick();
    chk_res("wd_r1", 1, -700);
    req_valid = 4'b1111;
    settle();
    chk("wd_next", {28'b0, req_ready}, 32'b0100);
    req_valid = 4'b0000;
    tick();
    tick();
    chk("wd_empty", {31'b0, res_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
